// File: rtl/period_meter.sv
// Tone period meter: counts iClk cycles between synchronized rising edges of iSig.
// Optional PERIOD_AVG4_EN averages four consecutive periods before reporting.
module period_meter #(
    parameter int          CNT_W   = 24,
    parameter int unsigned TIMEOUT = 16777215
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iSig,
    input  logic             iEn,
    output logic [CNT_W-1:0] oPeriod,
    output logic             oValid,
    output logic             oTimeout,
    output logic             oBusy
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise_q, rise_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             meas_done;
    logic [CNT_W-1:0] meas_val;
    logic             grp_clr;

`ifdef PERIOD_AVG4_EN
    logic [CNT_W+1:0] acc_q, acc_d, acc_sum;
    logic [1:0]       idx_q, idx_d;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;
        rise_d    = s2_q & ~s3_q;
        meas_done = 1'b0;
        grp_clr   = 1'b0;
        meas_val  = count_q + 1'b1;

        if (!iEn) begin
            state_d = IDLE;
            count_d = '0;
            grp_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    count_d = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise_q) begin
                        count_d = '0;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise on the last allowed cycle still counts as a measurement.
                    if (rise_q) begin
                        meas_done = 1'b1;
                        timeout_d = 1'b0;
                        count_d   = '0;
                    end else if (count_q == TO_LAST) begin
                        timeout_d = 1'b1;
                        count_d   = '0;
                        state_d   = ARM;
                        grp_clr   = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end

`ifdef PERIOD_AVG4_EN
        acc_d   = acc_q;
        idx_d   = idx_q;
        acc_sum = acc_q + {2'b00, meas_val};
        if (grp_clr) begin
            acc_d = '0;
            idx_d = '0;
        end else if (meas_done) begin
            if (idx_q == 2'd3) begin
                period_d = acc_sum[CNT_W+1:2];
                valid_d  = 1'b1;
                acc_d    = '0;
                idx_d    = '0;
            end else begin
                acc_d = acc_sum;
                idx_d = idx_q + 2'd1;
            end
        end
`else
        if (meas_done && !grp_clr) begin
            period_d = meas_val;
            valid_d  = 1'b1;
        end
`endif

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            rise_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef PERIOD_AVG4_EN
            acc_q     <= '0;
            idx_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            s1_q      <= iSig;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            rise_q    <= rise_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
`ifdef PERIOD_AVG4_EN
            acc_q     <= acc_d;
            idx_q     <= idx_d;
`endif
        end
    end

    assign oPeriod  = period_q;
    assign oValid   = valid_q;
    assign oTimeout = timeout_q;
    assign oBusy    = busy_q;

endmodule
